// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding window generator: shifts three aligned line-buffer taps into a
// register window and strobes post_frame_clken once the window holds real pixels.
module matrix_3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] row1_data,
    input  logic [DATA_WIDTH-1:0] row2_data,
    input  logic [DATA_WIDTH-1:0] row3_data,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output logic                  line_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] LINE_LEN = CNT_WIDTH'(IMG_WIDTH);
    localparam logic [CNT_WIDTH-1:0] BORDER   = CNT_WIDTH'(2);

    if ((IMG_WIDTH > (2**CNT_WIDTH) - 1) || (IMG_HEIGHT > (2**CNT_WIDTH) - 1)) begin : g_cnt_check
        $error("CNT_WIDTH too small for image dimensions");
    end

    logic                 pix_ok;
    logic                 vsync_rise;
    logic                 href_fall;
    logic                 win_ok;
    logic                 vsync_q;
    logic                 href_q;
    logic [CNT_WIDTH-1:0] col_cnt;
    logic [CNT_WIDTH-1:0] row_cnt;

    assign pix_ok     = per_frame_clken & per_frame_href;
    assign vsync_rise = per_frame_vsync & ~vsync_q;
    assign href_fall  = ~per_frame_href & href_q;
    // Counters are sampled pre-increment, so col_cnt >= 2 means two older columns are already in.
    assign win_ok     = pix_ok && (col_cnt >= BORDER) && (row_cnt >= BORDER);

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;

    // NOTE: the window is a handful of flops, not a RAM, so it is cheap to reset
    // and downstream filters never see stale data from a previous frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
            matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
            matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
        end else if (pix_ok) begin
            // NOTE: non-blocking assignments let every tap read its neighbour's old value.
            matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= row1_data;
            matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= row2_data;
            matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= row3_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q          <= 1'b0;
            href_q           <= 1'b0;
            post_frame_clken <= 1'b0;
            line_err         <= 1'b0;
        end else begin
            vsync_q          <= per_frame_vsync;
            href_q           <= per_frame_href;
            post_frame_clken <= win_ok;
            if (pix_ok && (col_cnt >= LINE_LEN))
                line_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
        end else if (!per_frame_href) begin
            col_cnt <= '0;
        end else if (pix_ok && (col_cnt != CNT_MAX)) begin
            col_cnt <= col_cnt + 1'b1;
        end
    end

    // A frame start overrides a coincident line end.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
        end else if (vsync_rise) begin
            row_cnt <= '0;
        end else if (href_fall && (row_cnt != CNT_MAX)) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen on an 8x4 image: reset, window contents,
// row gating, half-rate clken, overlong line and coincident vsync/href edges.
module tb_matrix_3x3_gen;

    logic       clk;
    logic       rst;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] row1_data;
    logic [7:0] row2_data;
    logic [7:0] row3_data;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic       line_err;

    int n_vec = 0;
    int n_err = 0;

    matrix_3x3_gen #(
        .DATA_WIDTH(8),
        .IMG_WIDTH (8),
        .IMG_HEIGHT(4),
        .CNT_WIDTH (11)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .row1_data       (row1_data),
        .row2_data       (row2_data),
        .row3_data       (row3_data),
        .matrix_p11      (matrix_p11),
        .matrix_p12      (matrix_p12),
        .matrix_p13      (matrix_p13),
        .matrix_p21      (matrix_p21),
        .matrix_p22      (matrix_p22),
        .matrix_p23      (matrix_p23),
        .matrix_p31      (matrix_p31),
        .matrix_p32      (matrix_p32),
        .matrix_p33      (matrix_p33),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .line_err        (line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Third-line vectors: pixel column driven, expected strobe and top-row window
    // (middle/bottom rows are the same columns offset by 0x10/0x20).
    typedef struct {
        logic [7:0] col;
        logic       exp_clken;
        logic [7:0] t1;
        logic [7:0] t2;
        logic [7:0] t3;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] win();
        return {matrix_p11, matrix_p12, matrix_p13,
                matrix_p21, matrix_p22, matrix_p23,
                matrix_p31, matrix_p32, matrix_p33};
    endfunction

    function automatic logic [71:0] exp_win(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] a2, b2, c2, a3, b3, c3;
        a2 = a + 8'h10; b2 = b + 8'h10; c2 = c + 8'h10;
        a3 = a + 8'h20; b3 = b + 8'h20; c3 = c + 8'h20;
        return {a, b, c, a2, b2, c2, a3, b3, c3};
    endfunction

    task automatic set_pix(input int col);
        row1_data = 8'(col + 8'h10);
        row2_data = 8'(col + 8'h20);
        row3_data = 8'(col + 8'h30);
    endtask

    task automatic start_frame();
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_frame_vsync = 1'b0;
        tick();
        tick();
        per_frame_vsync = 1'b1;
        tick();
    endtask

    // One line of npix pixels; half=1 inserts a clken=0 cycle before each pixel.
    // The two trailing href=0 cycles drive vsync to vs_end.
    task automatic send_line(input int npix, input bit half, input logic vs_end,
                             output int strobes, output bit hold_bad);
        logic [71:0] snap;
        strobes  = 0;
        hold_bad = 1'b0;
        per_frame_href = 1'b1;
        for (int c = 0; c < npix; c++) begin
            if (half) begin
                snap = win();
                per_frame_clken = 1'b0;
                row1_data = 8'hEE; row2_data = 8'hEE; row3_data = 8'hEE;
                tick();
                if (win() !== snap || post_frame_clken) hold_bad = 1'b1;
            end
            per_frame_clken = 1'b1;
            set_pix(c);
            tick();
            if (post_frame_clken) strobes++;
        end
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_frame_vsync = vs_end;
        tick();
        if (post_frame_clken) strobes++;
        tick();
        if (post_frame_clken) strobes++;
    endtask

    initial begin
        int  s0, s1, s2, s3, total;
        bit  hb, hb_any;

        tbl[0] = '{col: 8'd0, exp_clken: 1'b0, t1: 8'h16, t2: 8'h17, t3: 8'h10};
        tbl[1] = '{col: 8'd1, exp_clken: 1'b0, t1: 8'h17, t2: 8'h10, t3: 8'h11};
        tbl[2] = '{col: 8'd2, exp_clken: 1'b1, t1: 8'h10, t2: 8'h11, t3: 8'h12};
        tbl[3] = '{col: 8'd3, exp_clken: 1'b1, t1: 8'h11, t2: 8'h12, t3: 8'h13};
        tbl[4] = '{col: 8'd4, exp_clken: 1'b1, t1: 8'h12, t2: 8'h13, t3: 8'h14};
        tbl[5] = '{col: 8'd5, exp_clken: 1'b1, t1: 8'h13, t2: 8'h14, t3: 8'h15};
        tbl[6] = '{col: 8'd6, exp_clken: 1'b1, t1: 8'h14, t2: 8'h15, t3: 8'h16};
        tbl[7] = '{col: 8'd7, exp_clken: 1'b1, t1: 8'h15, t2: 8'h16, t3: 8'h17};

        // Reset held with live traffic.
        rst             = 1'b1;
        per_frame_vsync = 1'b1;
        per_frame_href  = 1'b1;
        per_frame_clken = 1'b1;
        set_pix(0);
        for (int k = 0; k < 5; k++) begin
            set_pix(k + 3);
            tick();
        end
        check("rst_window", win(), 72'h0);
        check("rst_post_vsync", 72'(post_frame_vsync), 72'h0);
        check("rst_post_href", 72'(post_frame_href), 72'h0);
        check("rst_post_clken", 72'(post_frame_clken), 72'h0);
        check("rst_line_err", 72'(line_err), 72'h0);

        rst = 1'b0;
        tick();
        check("post_rst_no_strobe", 72'(post_frame_clken), 72'h0);
        check("post_rst_vsync_delay", 72'(post_frame_vsync), 72'h1);
        check("post_rst_href_delay", 72'(post_frame_href), 72'h1);

        // Frame A: full-rate, third line checked vector by vector.
        start_frame();
        send_line(8, 1'b0, 1'b1, s0, hb);
        check("a_line0_strobes", 72'(s0), 72'd0);
        send_line(8, 1'b0, 1'b1, s1, hb);
        check("a_line1_strobes", 72'(s1), 72'd0);
        s2 = 0;
        per_frame_href = 1'b1;
        for (int i = 0; i < 8; i++) begin
            per_frame_clken = 1'b1;
            set_pix(int'(tbl[i].col));
            tick();
            check($sformatf("a_line2_col%0d_clken", i), 72'(post_frame_clken), 72'(tbl[i].exp_clken));
            check($sformatf("a_line2_col%0d_window", i), win(), exp_win(tbl[i].t1, tbl[i].t2, tbl[i].t3));
            if (post_frame_clken) s2++;
        end
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        tick();
        if (post_frame_clken) s2++;
        tick();
        if (post_frame_clken) s2++;
        check("a_line2_strobes", 72'(s2), 72'd6);
        send_line(8, 1'b0, 1'b1, s3, hb);
        check("a_line3_strobes", 72'(s3), 72'd6);
        total = s0 + s1 + s2 + s3;
        check("a_frame_strobes", 72'(total), 72'd12);

        // Frame B: half-rate clken; new vsync edge restarts at line 0.
        start_frame();
        hb_any = 1'b0;
        send_line(8, 1'b1, 1'b1, s0, hb); hb_any |= hb;
        check("b_line0_strobes", 72'(s0), 72'd0);
        send_line(8, 1'b1, 1'b1, s1, hb); hb_any |= hb;
        check("b_line1_strobes", 72'(s1), 72'd0);
        send_line(8, 1'b1, 1'b1, s2, hb); hb_any |= hb;
        check("b_line2_strobes", 72'(s2), 72'd6);
        send_line(8, 1'b1, 1'b1, s3, hb); hb_any |= hb;
        check("b_line3_strobes", 72'(s3), 72'd6);
        check("b_hold_on_gap", 72'(hb_any), 72'h0);
        check("b_line_err_clear", 72'(line_err), 72'h0);

        // Frame C: last line ends with href fall and vsync rise together.
        start_frame();
        send_line(8, 1'b0, 1'b1, s0, hb);
        send_line(8, 1'b0, 1'b1, s1, hb);
        send_line(8, 1'b0, 1'b1, s2, hb);
        check("c_line2_strobes", 72'(s2), 72'd6);
        per_frame_vsync = 1'b0;
        send_line(8, 1'b0, 1'b1, s3, hb);
        check("c_line3_vsync_low_strobes", 72'(s3), 72'd6);
        send_line(8, 1'b0, 1'b1, s0, hb);
        check("c_next_line0_strobes", 72'(s0), 72'd0);
        send_line(8, 1'b0, 1'b1, s1, hb);
        check("c_next_line1_strobes", 72'(s1), 72'd0);
        send_line(8, 1'b0, 1'b1, s2, hb);
        check("c_next_line2_strobes", 72'(s2), 72'd6);

        // Frame D: overlong line sets the sticky error.
        start_frame();
        per_frame_href = 1'b1;
        for (int c = 0; c < 10; c++) begin
            per_frame_clken = 1'b1;
            set_pix(c);
            tick();
            if (c == 7) check("d_err_after_8th", 72'(line_err), 72'h0);
            if (c == 8) check("d_err_after_9th", 72'(line_err), 72'h1);
        end
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        tick();
        start_frame();
        send_line(8, 1'b0, 1'b1, s0, hb);
        check("d_err_sticky_next_frame", 72'(line_err), 72'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("d_err_cleared_by_rst", 72'(line_err), 72'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
